// File: rtl/ohfsm_pkg.sv
// Shared definitions for the one-hot sequencer: advance-mode encodings,
// bounce direction, and a one-hot validity check used for state recovery.
package ohfsm_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // True when exactly one bit is set; callers zero-extend to 32 bits.
  function automatic logic onehot_valid(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/ohfsm_prescaler.sv
// Advance prescaler: counts enabled cycles and flags a tick once the count
// reaches div, so the sequencer advances every div+1 enabled cycles.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   en         : count enable; when low the count holds and no tick is raised
//   clr        : force the count to zero (accepted load or state recovery)
//   stall      : hold the count (rejected load)
//   div        : divide value
//   tick_c     : combinational advance strobe
module ohfsm_prescaler #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             stall,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // >= rather than == so a div lowered below the running count ticks at once.
  assign tick_c = en && (cnt_q >= div);

  // Count update, clear and stall take precedence over normal counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q;
    end else if (tick_c) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ohfsm_seq.sv
// Parametrised one-hot state sequencer with prescaled advance, hold/up/down/
// bounce modes, synchronous load, end-of-sequence pulse and recovery from a
// corrupted (non one-hot) state vector.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   en         : prescaler enable
//   mode       : 00 hold, 01 up, 10 down, 11 bounce
//   div        : advance every div+1 enabled cycles
//   load       : load request, load_idx selects the target state
//   out        : one-hot state vector
//   idx        : binary index of the active bit
//   wrap       : one-cycle end-of-sequence pulse
//   err        : one-cycle pulse on rejected load or state recovery
module ohfsm_seq
  import ohfsm_pkg::*;
#(
  parameter int unsigned  N         = 8,
  parameter int unsigned  RESET_IDX = 0,
  parameter int unsigned  DIV_W     = 4,
  localparam int unsigned IDX_W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [N-1:0]     out,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] RST_IDX  = IDX_W'(RESET_IDX);

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] i);
    return N'(1) << i;
  endfunction

  logic [N-1:0]     out_q, out_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  dir_e             dir_q, dir_d;

  mode_t mode_c;
  logic  tick_c;
  logic  legal_c;
  logic  load_ok_c;
  logic  cnt_clr_c;
  logic  cnt_stall_c;
  logic  bounce_up_c;

  assign mode_c    = mode_t'(mode);
  assign legal_c   = onehot_valid(32'(out_q));
  assign load_ok_c = (32'(load_idx) < N);

  ohfsm_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (cnt_clr_c),
    .stall  (cnt_stall_c),
    .div    (div),
    .tick_c (tick_c)
  );

  // Next state: recovery > load > tick.
  always_comb begin
    out_d       = out_q;
    idx_d       = idx_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    cnt_clr_c   = 1'b0;
    cnt_stall_c = 1'b0;
    bounce_up_c = 1'b0;

    if (!legal_c) begin
      idx_d     = RST_IDX;
      out_d     = to_onehot(RST_IDX);
      dir_d     = DIR_UP;
      err_d     = 1'b1;
      cnt_clr_c = 1'b1;
    end else if (load) begin
      if (load_ok_c) begin
        idx_d     = load_idx;
        out_d     = to_onehot(load_idx);
        dir_d     = DIR_UP;
        cnt_clr_c = 1'b1;
      end else begin
        err_d       = 1'b1;
        cnt_stall_c = 1'b1;
      end
    end else if (tick_c) begin
      case (mode_c)
        MODE_HOLD: begin
        end
        MODE_UP: begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        MODE_DOWN: begin
          if (idx_q == '0) begin
            idx_d  = LAST_IDX;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        MODE_BOUNCE: begin
          // Sitting on an end already facing outward reflects instead of stepping past it.
          bounce_up_c = (dir_q == DIR_UP) ? (idx_q != LAST_IDX) : (idx_q == '0);
          if (bounce_up_c) begin
            idx_d  = idx_q + IDX_W'(1);
            wrap_d = (idx_d == LAST_IDX);
            dir_d  = (idx_d == LAST_IDX) ? DIR_DOWN : DIR_UP;
          end else begin
            idx_d  = idx_q - IDX_W'(1);
            wrap_d = (idx_d == '0);
            dir_d  = (idx_d == '0) ? DIR_UP : DIR_DOWN;
          end
        end
        default: begin
        end
      endcase
      out_d = to_onehot(idx_d);
    end
  end

  // State, index, direction and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= to_onehot(RST_IDX);
      idx_q  <= RST_IDX;
      dir_q  <= DIR_UP;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ohfsm_seq.sv
// Bench for ohfsm_seq: a behavioural model pushes the expected registered
// outputs for each driven cycle; scenario tasks pop and compare after the edge.
// A second N=5 instance exercises out-of-range load rejection.
module tb_ohfsm_seq;
  import ohfsm_pkg::*;

  localparam int unsigned N         = 8;
  localparam int unsigned RESET_IDX = 0;
  localparam int unsigned DIV_W     = 4;
  localparam int unsigned IDX_W     = 3;
  localparam int          N8        = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [N-1:0]     out;
  logic [IDX_W-1:0] idx;
  logic             wrap;
  logic             err;
  logic [4:0]       out5;
  logic [2:0]       idx5;
  logic             wrap5;
  logic             err5;

  always #5 clk = ~clk;

  ohfsm_seq #(.N(N), .RESET_IDX(RESET_IDX), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div), .load(load),
    .load_idx(load_idx), .out(out), .idx(idx), .wrap(wrap), .err(err)
  );

  ohfsm_seq #(.N(5), .RESET_IDX(1), .DIV_W(DIV_W)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div), .load(load),
    .load_idx(load_idx), .out(out5), .idx(idx5), .wrap(wrap5), .err(err5)
  );

  typedef struct packed {
    logic [N-1:0]     out;
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_idx    = 0;
  int   m_cnt    = 0;
  bit   m_down   = 1'b0;

  // Model of one clock edge for the N=8 instance, from the inputs now applied.
  task automatic model_step();
    exp_t e;
    bit   w;
    bit   er;
    w  = 1'b0;
    er = 1'b0;
    if (!rst_n) begin
      m_idx = RESET_IDX; m_cnt = 0; m_down = 1'b0;
    end else if (load) begin
      if (int'(load_idx) < N8) begin
        m_idx = int'(load_idx); m_cnt = 0; m_down = 1'b0;
      end else begin
        er = 1'b1;
      end
    end else if (en) begin
      if (m_cnt >= int'(div)) begin
        m_cnt = 0;
        case (mode)
          MODE_UP: begin
            m_idx = (m_idx + 1) % N8;
            w     = (m_idx == 0);
          end
          MODE_DOWN: begin
            m_idx = (m_idx + N8 - 1) % N8;
            w     = (m_idx == N8 - 1);
          end
          MODE_BOUNCE: begin
            if (!m_down && m_idx == N8 - 1) m_down = 1'b1;
            else if (m_down && m_idx == 0) m_down = 1'b0;
            m_idx = m_down ? m_idx - 1 : m_idx + 1;
            if (m_idx == N8 - 1 || m_idx == 0) begin
              w      = 1'b1;
              m_down = (m_idx == N8 - 1);
            end
          end
          default: begin
          end
        endcase
      end else begin
        m_cnt++;
      end
    end
    e.out         = '0;
    e.out[m_idx]  = 1'b1;
    e.idx         = IDX_W'(m_idx);
    e.wrap        = w;
    e.err         = er;
    sb_q.push_back(e);
  endtask

  task automatic drive_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; div = '0; load = 1'b0; load_idx = '0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(); e = sb_q.pop_front(); checks++;
      if ({out, idx, wrap, err} !== e) begin
        failures++; $display("FAIL reset i=%0d got=%h exp=%h", i, {out, idx, wrap, err}, e);
      end
    end
    checks++;
    if ({out5, idx5, wrap5, err5} !== {5'b00010, 3'd1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_n5 got=%h exp=%h", {out5, idx5, wrap5, err5}, {5'b00010, 3'd1, 2'b00});
    end
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(); e = sb_q.pop_front(); checks++;
      if ({out, idx, wrap, err} !== e) begin
        failures++; $display("FAIL hold i=%0d got=%h exp=%h", i, {out, idx, wrap, err}, e);
      end
    end
  endtask

  task automatic test_load_reject();
    exp_t e;
    mode = MODE_HOLD; load = 1'b1; load_idx = 3'd6;
    drive_cycle(); e = sb_q.pop_front(); checks++;
    if ({out, idx, wrap, err} !== e) begin
      failures++; $display("FAIL load6_n8 got=%h exp=%h", {out, idx, wrap, err}, e);
    end
    checks++;
    if ({out5, idx5, wrap5, err5} !== {5'b00010, 3'd1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reject_n5 got=%h exp=%h", {out5, idx5, wrap5, err5}, {5'b00010, 3'd1, 2'b01});
    end
    load = 1'b0;
    drive_cycle(); e = sb_q.pop_front();
    checks++;
    if ({out5, idx5, wrap5, err5} !== {5'b00010, 3'd1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reject_pulse_n5 got=%h exp=%h", {out5, idx5, wrap5, err5}, {5'b00010, 3'd1, 2'b00});
    end
    load = 1'b1; load_idx = 3'd4;
    drive_cycle(); e = sb_q.pop_front();
    checks++;
    if ({out5, idx5, wrap5, err5} !== {5'b10000, 3'd4, 1'b0, 1'b0}) begin
      failures++; $display("FAIL load4_n5 got=%h exp=%h", {out5, idx5, wrap5, err5}, {5'b10000, 3'd4, 2'b00});
    end
    checks++;
    if ({out, idx, wrap, err} !== e) begin
      failures++; $display("FAIL load4_n8 got=%h exp=%h", {out, idx, wrap, err}, e);
    end
    load = 1'b0;
  endtask

  task automatic test_up();
    exp_t e;
    load = 1'b1; load_idx = 3'd0; mode = MODE_UP; div = 4'd0; en = 1'b1;
    drive_cycle(); e = sb_q.pop_front(); checks++;
    if ({out, idx, wrap, err} !== e) begin
      failures++; $display("FAIL up_load got=%h exp=%h", {out, idx, wrap, err}, e);
    end
    load = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (i == 9)  div = 4'd2;
      if (i == 17) en = 1'b0;
      if (i == 22) en = 1'b1;
      if (i == 28) div = 4'd5;
      if (i == 31) div = 4'd1;
      drive_cycle(); e = sb_q.pop_front(); checks++;
      if ({out, idx, wrap, err} !== e) begin
        failures++; $display("FAIL up_walk i=%0d got=%h exp=%h", i, {out, idx, wrap, err}, e);
      end
    end
  endtask

  task automatic test_down_bounce();
    exp_t e;
    load = 1'b1; load_idx = 3'd0; div = 4'd0; en = 1'b1;
    drive_cycle(); e = sb_q.pop_front();
    load = 1'b0; mode = MODE_DOWN;
    for (int i = 0; i < 22; i++) begin
      if (i == 8) mode = MODE_BOUNCE;
      drive_cycle(); e = sb_q.pop_front(); checks++;
      if ({out, idx, wrap, err} !== e) begin
        failures++; $display("FAIL down_bounce i=%0d got=%h exp=%h", i, {out, idx, wrap, err}, e);
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    mode = MODE_UP; div = 4'd0; en = 1'b1; load = 1'b1; load_idx = 3'd7;
    drive_cycle(); e = sb_q.pop_front();
    load_idx = 3'd5;
    drive_cycle(); e = sb_q.pop_front(); checks++;
    if ({out, idx, wrap, err} !== e) begin
      failures++; $display("FAIL load_vs_tick got=%h exp=%h", {out, idx, wrap, err}, e);
    end
    load = 1'b0; div = 4'd2;
    for (int i = 0; i < 7; i++) begin
      load = (i == 2);
      load_idx = 3'd2;
      drive_cycle(); e = sb_q.pop_front(); checks++;
      if ({out, idx, wrap, err} !== e) begin
        failures++; $display("FAIL load_cnt i=%0d got=%h exp=%h", i, {out, idx, wrap, err}, e);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_illegal();
    exp_t e;
    mode = MODE_HOLD; en = 1'b0; div = 4'd0;
    for (int k = 0; k < 2; k++) begin
      load = 1'b1; load_idx = (k == 0) ? 3'd3 : 3'd6;
      drive_cycle(); e = sb_q.pop_front();
      load = 1'b0;
      if (k == 0) force dut.out_q = 8'b0001_0100;
      else        force dut.out_q = 8'b0000_0000;
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b1 || idx !== 3'd0) begin
        failures++; $display("FAIL illegal_err k=%0d err=%b idx=%0d exp err=1 idx=0", k, err, idx);
      end
      release dut.out_q;
      @(posedge clk); #1;
      checks++;
      if (out !== 8'h01 || idx !== 3'd0 || wrap !== 1'b0) begin
        failures++; $display("FAIL illegal_out k=%0d out=%h idx=%0d wrap=%b exp out=01 idx=0 wrap=0", k, out, idx, wrap);
      end
      m_idx = RESET_IDX; m_cnt = 0; m_down = 1'b0;
      drive_cycle(); e = sb_q.pop_front(); checks++;
      if ({out, idx, wrap, err} !== e) begin
        failures++; $display("FAIL illegal_after k=%0d got=%h exp=%h", k, {out, idx, wrap, err}, e);
      end
    end
  endtask

  task automatic test_reset_bounce();
    exp_t e;
    load = 1'b1; load_idx = 3'd0; mode = MODE_BOUNCE; div = 4'd0; en = 1'b1;
    drive_cycle(); e = sb_q.pop_front();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(); e = sb_q.pop_front();
    end
    checks++;
    if (idx !== 3'd4) begin
      failures++; $display("FAIL bounce_pre_reset idx=%0d exp=4", idx);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) rst_n = 1'b1;
      drive_cycle(); e = sb_q.pop_front(); checks++;
      if ({out, idx, wrap, err} !== e) begin
        failures++; $display("FAIL reset_bounce i=%0d got=%h exp=%h", i, {out, idx, wrap, err}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_reject();
    test_up();
    test_down_bounce();
    test_load();
    test_illegal();
    test_reset_bounce();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_drain left=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
